// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, issues one ROM read at a time,
// captures the registered ROM word and hands it to decode over valid/ready.
// Jumps and halts from decode are taken only in HALT or at a HOLD handshake.
module fetch_sequencer #(
  parameter int s_addr = 6,
  parameter int s_word = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [s_addr-1:0] jump_addr,
  output logic [s_addr-1:0] mem_address,
  output logic              mem_enable,
  input  logic [s_word-1:0] mem_data,
  output logic [s_word-1:0] instr,
  output logic [s_addr-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [s_addr-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_handshake;
  logic              w_mem_enable;
  logic [s_addr-1:0] r_pc;
  logic [s_word-1:0] r_instr;
  logic [s_addr-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_halted;

  assign w_handshake = (r_state == ST_HOLD) && instr_ready;

  // State register: reset always returns to HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: run leaves HALT unless halt_req arrives with it;
  // ISSUE and CAPTURE advance unconditionally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HALT:    if (run && !halt_req) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_HOLD;
      ST_HOLD:    if (instr_ready) w_next = halt_req ? ST_HALT : ST_ISSUE;
      default:    w_next = ST_HALT;
    endcase
  end

  // Output decode: the ROM is enabled only while a read is being issued.
  always_comb begin
    w_mem_enable = 1'b0;
    if (r_state == ST_ISSUE) w_mem_enable = 1'b1;
  end

  // Datapath: PC update, instruction capture and the registered status flags.
  // The PC is incremented at capture so a handshake jump simply overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b1;
    end else begin
      r_halted <= (w_next == ST_HALT);
      case (r_state)
        ST_HALT: begin
          if (jump_valid) r_pc <= jump_addr;
        end
        ST_CAPTURE: begin
          r_instr       <= mem_data;
          r_instr_pc    <= r_pc;
          r_instr_valid <= 1'b1;
          r_pc          <= r_pc + 1'b1;
        end
        ST_HOLD: begin
          if (w_handshake) begin
            r_instr_valid <= 1'b0;
            if (jump_valid) r_pc <= jump_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_address = r_pc;
  assign mem_enable  = w_mem_enable;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a registered ROM model whose word
// at address k is 16'h1000+k; outside an enabled read it drives a poison word.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        jump_valid;
  logic [5:0]  jump_addr;
  logic [5:0]  mem_address;
  logic        mem_enable;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  pc;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.s_addr(6), .s_word(16)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .mem_address(mem_address), .mem_enable(mem_enable), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted)
  );

  // Registered ROM: data appears the cycle after an enabled read.
  always_ff @(posedge clk) begin
    if (mem_enable) mem_data <= 16'h1000 + {10'd0, mem_address};
    else            mem_data <= 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered just after the edge into ISSUE; returns just after the edge into HOLD.
  task automatic fetch(input logic [5:0] addr);
    logic [5:0] nxt;
    nxt = addr + 6'd1;
    chk("issue_en", {31'd0, mem_enable}, 32'd1);
    chk("issue_addr", {26'd0, mem_address}, {26'd0, addr});
    chk("issue_vld", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("capt_en", {31'd0, mem_enable}, 32'd0);
    tick();
    chk("hold_vld", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", {16'd0, instr}, 32'h1000 + {26'd0, addr});
    chk("hold_ipc", {26'd0, instr_pc}, {26'd0, addr});
    chk("hold_pc", {26'd0, pc}, {26'd0, nxt});
    chk("hold_halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_pc"}, {26'd0, pc}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    chk({tag, "_en"}, {31'd0, mem_enable}, 32'd0);
    chk({tag, "_instr"}, {16'd0, instr}, 32'd0);
    chk({tag, "_ipc"}, {26'd0, instr_pc}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; jump_valid = 1'b0;
    jump_addr = 6'd0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Reset then start, ready held high: one word per three cycles.
    instr_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch(6'd0);
    tick(); fetch(6'd1);
    tick(); fetch(6'd2);

    // Backpressure; jump/halt requests without ready are ignored.
    instr_ready = 1'b0;
    jump_valid = 1'b1; jump_addr = 6'd50; halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_vld", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", {16'd0, instr}, 32'h1002);
      chk("bp_ipc", {26'd0, instr_pc}, 32'd2);
      chk("bp_en", {31'd0, mem_enable}, 32'd0);
      chk("bp_pc", {26'd0, pc}, 32'd3);
    end
    jump_valid = 1'b0; halt_req = 1'b0;
    instr_ready = 1'b1;
    tick(); fetch(6'd3);
    tick(); fetch(6'd4);

    // Jump at the handshake of instr_pc 4.
    jump_valid = 1'b1; jump_addr = 6'd40;
    tick();
    jump_valid = 1'b0;
    fetch(6'd40);

    // Jump during CAPTURE is dropped.
    tick();
    chk("cj_issue_addr", {26'd0, mem_address}, 32'd41);
    tick();
    jump_valid = 1'b1; jump_addr = 6'd20;
    tick();
    jump_valid = 1'b0;
    chk("cj_ipc", {26'd0, instr_pc}, 32'd41);
    chk("cj_pc", {26'd0, pc}, 32'd42);
    tick(); fetch(6'd42);

    // Halt at a handshake, run+halt_req stays halted, preset start address.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_vld", {31'd0, instr_valid}, 32'd0);
    chk("halt_pc", {26'd0, pc}, 32'd43);
    run = 1'b1; halt_req = 1'b1;
    tick();
    run = 1'b0; halt_req = 1'b0;
    chk("runhalt_halted", {31'd0, halted}, 32'd1);
    chk("runhalt_en", {31'd0, mem_enable}, 32'd0);
    jump_valid = 1'b1; jump_addr = 6'd10;
    tick();
    jump_valid = 1'b0;
    chk("preset_pc", {26'd0, pc}, 32'd10);
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch(6'd10);

    // Wrap-around from 63 to 0.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    jump_valid = 1'b1; jump_addr = 6'd63;
    tick();
    jump_valid = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch(6'd63);
    tick(); fetch(6'd0);

    // Reset in CAPTURE.
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_capt");

    // Reset in HOLD.
    instr_ready = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick();
    chk("rh_vld", {31'd0, instr_valid}, 32'd1);
    chk("rh_instr", {16'd0, instr}, 32'h1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_hold");
    tick();
    chk("post_rst_halted", {31'd0, halted}, 32'd1);
    chk("post_rst_en", {31'd0, mem_enable}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetches from the program ROM for the Karpentium core. It owns the program counter and drives the ROM address and enable, capturing each registered ROM word one cycle later. It presents the word to decode over a valid/ready handshake, and takes jumps and halts from decode. It sits between `program_memory` and the decode/control unit.

## Interface
- `s_addr`, default 6: ROM address width; the PC width.
- `s_word`, default 16: instruction word width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; leaves HALT and starts fetching.
- `halt_req`  in  1  stop after the instruction being handed off.
- `jump_valid`  in  1  load PC from `jump_addr` (see Operation).
- `jump_addr`  in  s_addr  jump target.
- `mem_address`  out  s_addr  ROM address; equals `pc` combinationally.
- `mem_enable`  out  1  ROM enable; high only in ISSUE.
- `mem_data`  in  s_word  ROM registered read data.
- `instr`  out  s_word  captured instruction word.
- `instr_pc`  out  s_addr  address that `instr` was fetched from.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `pc`  out  s_addr  current program counter.
- `halted`  out  1  high while in HALT.

## Operation
- Reset values:
  - state = HALT, `pc` = 0, `instr` = 0, `instr_pc` = 0.
  - `instr_valid` = 0, `mem_enable` = 0, `halted` = 1.
- States are HALT, ISSUE, CAPTURE and HOLD.
- **HALT**
  - `halted` = 1.
  - If `jump_valid`, then `pc` <= `jump_addr`; this sets the start address.
  - If `run` and not `halt_req`, go to ISSUE. If `run` and `halt_req` arrive together, stay in HALT.
- **ISSUE**
  - `mem_enable` = 1 and `mem_address` = `pc`. The ROM registers `pdra[pc]` at the end of this cycle.
  - Next state is CAPTURE. All inputs are ignored.
- **CAPTURE**
  - `mem_data` is valid during this cycle.
  - At the edge: `instr` <= `mem_data`, `instr_pc` <= `pc`, `instr_valid` <= 1, `pc` <= `pc` + 1.
  - Next state is HOLD. All inputs are ignored.
- **HOLD**
  - `instr`, `instr_pc` and `instr_valid` = 1 are held stable until `instr_ready`.
  - On handshake (`instr_ready` = 1):
    - `instr_valid` <= 0.
    - If `jump_valid`, then `pc` <= `jump_addr`; the jump has priority over the already-incremented `pc`.
    - Next state is HALT if `halt_req`, otherwise ISSUE.
  - Without `instr_ready`, `jump_valid` and `halt_req` are ignored.
- `jump_valid` is sampled only in HALT or on a HOLD handshake. Jumps in ISSUE or CAPTURE are dropped; decode must not issue them.
- PC arithmetic is unsigned modulo 2^s_addr. `pc` = 2^s_addr − 1 increments to 0, with no error flag.
- `mem_enable` is low in every state except ISSUE. The ROM then tri-states its output, and this block never samples `mem_data` outside CAPTURE.

## Timing
- Fetch latency from entering ISSUE to `instr_valid` high is 2 cycles.
- Minimum throughput is 3 cycles per instruction (ISSUE → CAPTURE → HOLD with `instr_ready` held high).
- `run` asserted in HALT at edge N gives:
  - ISSUE in cycle N+1;
  - `instr_valid` high from cycle N+3.
- A handshake at edge M means:
  - `instr_valid` is low in cycle M+1 (ISSUE);
  - the next `instr_valid` is high in cycle M+3.
- Reset mid-operation, at any state: the next edge forces all reset values. Any fetched or held instruction is discarded, with no handshake.
- All outputs are registered except `mem_address`, which equals `pc`, and `mem_enable`, which is decoded from state. Both are glitch-free relative to `clk` edges.

## Test plan
- **Reset then start**
  - Stimulus: ROM holds word k = 16'h1000+k. Assert `rst` for 2 cycles, then `run` = 1 with `instr_ready` = 1.
  - Required: `instr` sequence 16'h1000, 16'h1001, 16'h1002, one word per 3 cycles; `instr_pc` = 0, 1, 2; first `instr_valid` 3 cycles after `run`.
- **Backpressure**
  - Stimulus: hold `instr_ready` = 0 for 5 cycles in HOLD.
  - Required: `instr`/`instr_pc` stable; `mem_enable` stays 0; no `pc` change past the +1; the next fetch starts the cycle after ready.
- **Jump on handshake**
  - Stimulus: at the handshake of `instr_pc` = 4, drive `jump_valid` = 1, `jump_addr` = 6'd40.
  - Required: the next `mem_address` in ISSUE = 40 and the next `instr_pc` = 40.
  - Also: `jump_valid` driven during CAPTURE has no effect.
- **Halt and restart from a preset address**
  - Stimulus: `halt_req` at a handshake; then, in HALT, `jump_valid` with `jump_addr` = 10, then `run`.
  - Required: `halted` = 1 after the handshake; the next fetch address is 10.
  - Also: `run` together with `halt_req` in HALT stays halted.
- **Wrap-around**
  - Stimulus: fetch at `pc` = 63 with s_addr = 6.
  - Required: `instr_pc` = 63, then `pc` = 0 and the next fetch address is 0.
- **Reset mid-fetch**
  - Stimulus: assert `rst` in CAPTURE and separately in HOLD.
  - Required: the next cycle shows all outputs at reset values: `instr_valid` = 0, `pc` = 0, `halted` = 1.
